// File: rtl/pll_reset_gen_pkg.sv
// Shared definitions for the PLL reset generator: FSM state encodings and the
// width of the debug 'state' output, also decoded by the CSR block.
package pll_reset_gen_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_WAIT_LOCK = 2'd0,
        ST_FILTER    = 2'd1,
        ST_HOLD      = 2'd2,
        ST_RUN       = 2'd3
    } rst_state_e;

    // Counter width able to hold the larger of the two qualification lengths.
    function automatic int cnt_width(input int lock_filter, input int hold_cycles);
        int longest;
        longest = (lock_filter > hold_cycles) ? lock_filter : hold_cycles;
        return $clog2(longest + 1);
    endfunction

endpackage

// File: rtl/pll_reset_gen_if.sv
// Signal bundle between the PLL reset generator and its consumers.
// RSTGEN_SOFTRST_EN adds the soft_req input to the bundle.
interface pll_reset_gen_if #(
    parameter int LOSS_CNT_W = 8
);
    import pll_reset_gen_pkg::*;

    logic                  pll_locked;
`ifdef RSTGEN_SOFTRST_EN
    logic                  soft_req;
`endif
    logic                  sys_resetn;
    logic                  ready;
    logic [STATE_W-1:0]    state;
    logic [LOSS_CNT_W-1:0] lock_loss_cnt;

`ifdef RSTGEN_SOFTRST_EN
    modport master (
        input  pll_locked,
        input  soft_req,
        output sys_resetn,
        output ready,
        output state,
        output lock_loss_cnt
    );

    modport slave (
        output pll_locked,
        output soft_req,
        input  sys_resetn,
        input  ready,
        input  state,
        input  lock_loss_cnt
    );
`else
    modport master (
        input  pll_locked,
        output sys_resetn,
        output ready,
        output state,
        output lock_loss_cnt
    );

    modport slave (
        output pll_locked,
        input  sys_resetn,
        input  ready,
        input  state,
        input  lock_loss_cnt
    );
`endif

endinterface

// File: rtl/pll_reset_gen_sync_ff.sv
// Generic single-bit flop-chain synchronizer; the whole chain clears on resetn.
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic resetn,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/pll_reset_gen.sv
// Turns the asynchronous PLL lock flag into a filtered, stretched, synchronous
// active-low system reset. RSTGEN_SOFTRST_EN enables the soft reset request.
module pll_reset_gen
    import pll_reset_gen_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int LOCK_FILTER = 1024,
    parameter int HOLD_CYCLES = 16,
    parameter int LOSS_CNT_W  = 8
) (
    input  logic            clk,
    input  logic            resetn,
    pll_reset_gen_if.master bus
);

    localparam int CNT_W = cnt_width(LOCK_FILTER, HOLD_CYCLES);
    localparam logic [CNT_W-1:0] FILTER_LAST = CNT_W'(LOCK_FILTER - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);

    rst_state_e            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [LOSS_CNT_W-1:0] loss_q, loss_d;
    logic                  run_q;
    logic                  lock_s;
    logic                  soft_s;

    function automatic logic [LOSS_CNT_W-1:0] sat_inc(input logic [LOSS_CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    sync_ff #(.STAGES(SYNC_STAGES)) u_lock_sync (
        .clk    (clk),
        .resetn (resetn),
        .d      (bus.pll_locked),
        .q      (lock_s)
    );

    // soft_req originates in the clk domain, so it is used without a synchronizer.
`ifdef RSTGEN_SOFTRST_EN
    assign soft_s = bus.soft_req;
`else
    assign soft_s = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        loss_d  = loss_q;
        case (state_q)
            ST_WAIT_LOCK: begin
                if (lock_s) begin
                    state_d = ST_FILTER;
                    cnt_d   = '0;
                end
            end
            ST_FILTER: begin
                if (!lock_s) begin
                    state_d = ST_WAIT_LOCK;
                end else if (cnt_q == FILTER_LAST) begin
                    state_d = ST_HOLD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_HOLD: begin
                if (!lock_s) begin
                    state_d = ST_WAIT_LOCK;
                end else if (cnt_q == HOLD_LAST) begin
                    state_d = ST_RUN;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RUN: begin
                // Lock loss outranks a simultaneous soft request.
                if (!lock_s) begin
                    state_d = ST_WAIT_LOCK;
                    loss_d  = sat_inc(loss_q);
                end else if (soft_s) begin
                    state_d = ST_HOLD;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_WAIT_LOCK;
            end
        endcase
    end

    // sys_resetn is registered from next_state so it tracks state entry/exit of RUN.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= ST_WAIT_LOCK;
            cnt_q   <= '0;
            loss_q  <= '0;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            loss_q  <= loss_d;
            run_q   <= (state_d == ST_RUN);
        end
    end

    assign bus.sys_resetn    = run_q;
    assign bus.ready         = run_q;
    assign bus.state         = state_q;
    assign bus.lock_loss_cnt = loss_q;

endmodule

// File: tb/tb_pll_reset_gen.sv
// Scoreboard bench for pll_reset_gen: a default-parameter instance and a small
// instance with a 2-bit loss counter; RSTGEN_SOFTRST_EN adds soft reset tests.
`timescale 1ns/1ps
module tb_pll_reset_gen;
    import pll_reset_gen_pkg::*;

    localparam int SYNC  = 2;
    localparam int LF    = 1024;
    localparam int HC    = 16;
    localparam int LAT   = SYNC + 1 + LF + HC;
    localparam int S_LF  = 4;
    localparam int S_HC  = 3;
    localparam int S_LAT = SYNC + 1 + S_LF + S_HC;

    logic clk     = 1'b0;
    logic resetn  = 1'b0;
    logic sresetn = 1'b0;
    int   cyc     = 0;
    int   checks  = 0;
    int   errors  = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    pll_reset_gen_if #(.LOSS_CNT_W(8)) bus ();
    pll_reset_gen_if #(.LOSS_CNT_W(2)) sbus ();

    pll_reset_gen #(
        .SYNC_STAGES(SYNC), .LOCK_FILTER(LF), .HOLD_CYCLES(HC), .LOSS_CNT_W(8)
    ) dut (
        .clk(clk), .resetn(resetn), .bus(bus)
    );

    pll_reset_gen #(
        .SYNC_STAGES(SYNC), .LOCK_FILTER(S_LF), .HOLD_CYCLES(S_HC), .LOSS_CNT_W(2)
    ) dut_s (
        .clk(clk), .resetn(sresetn), .bus(sbus)
    );

    typedef struct {
        bit rise;
        int at;
        int loss;
        int st;
    } ev_t;

    ev_t exp_q[$];
    ev_t sexp_q[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic push_main(input bit rise, input int at, input int loss, input int st);
        ev_t e;
        e.rise = rise; e.at = at; e.loss = loss; e.st = st;
        exp_q.push_back(e);
    endtask

    task automatic push_small(input bit rise, input int at, input int loss, input int st);
        ev_t e;
        e.rise = rise; e.at = at; e.loss = loss; e.st = st;
        sexp_q.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    logic prev_rn  = 1'b0;
    logic sprev_rn = 1'b0;

    always @(negedge clk) begin
        if (bus.sys_resetn !== prev_rn) begin
            if (exp_q.size() == 0) begin
                check("main_unexpected_edge", bus.sys_resetn, prev_rn);
            end else begin
                ev_t e;
                e = exp_q.pop_front();
                check("main_edge_dir", bus.sys_resetn, e.rise);
                check("main_edge_cycle", cyc, e.at);
                check("main_loss_cnt", bus.lock_loss_cnt, e.loss);
                check("main_ready", bus.ready, e.rise);
                check("main_state", bus.state, e.st);
            end
        end
        prev_rn <= bus.sys_resetn;
    end

    always @(negedge clk) begin
        if (sbus.sys_resetn !== sprev_rn) begin
            if (sexp_q.size() == 0) begin
                check("small_unexpected_edge", sbus.sys_resetn, sprev_rn);
            end else begin
                ev_t e;
                e = sexp_q.pop_front();
                check("small_edge_dir", sbus.sys_resetn, e.rise);
                check("small_edge_cycle", cyc, e.at);
                check("small_loss_cnt", sbus.lock_loss_cnt, e.loss);
                check("small_ready", sbus.ready, e.rise);
                check("small_state", sbus.state, e.st);
            end
        end
        sprev_rn <= sbus.sys_resetn;
    end

    initial begin
        int loss;
        int c;
        bus.pll_locked  = 1'b0;
        sbus.pll_locked = 1'b0;
`ifdef RSTGEN_SOFTRST_EN
        bus.soft_req  = 1'b0;
        sbus.soft_req = 1'b0;
`endif
        step(3);
        check("reset_sys_resetn", bus.sys_resetn, 1'b0);
        check("reset_ready", bus.ready, 1'b0);
        check("reset_state", bus.state, ST_WAIT_LOCK);
        check("reset_loss", bus.lock_loss_cnt, 0);

        // Constant lock from reset release on both instances.
        resetn = 1'b1; sresetn = 1'b1;
        bus.pll_locked = 1'b1; sbus.pll_locked = 1'b1;
        push_main(1'b1, cyc + LAT, 0, ST_RUN);
        push_small(1'b1, cyc + S_LAT, 0, ST_RUN);
        step(S_LAT + 3);

        // Repeated lock loss on the small instance saturates its 2-bit counter.
        for (int i = 0; i < 6; i++) begin
            loss = (i + 1 > 3) ? 3 : i + 1;
            sbus.pll_locked = 1'b0;
            push_small(1'b0, cyc + SYNC + 1, loss, ST_WAIT_LOCK);
            step(6);
            sbus.pll_locked = 1'b1;
            push_small(1'b1, cyc + S_LAT, loss, ST_RUN);
            step(S_LAT + 3);
        end
        check("small_saturated", sbus.lock_loss_cnt, 3);

        // Glitch during HOLD on the small instance restarts qualification.
        sbus.pll_locked = 1'b0;
        push_small(1'b0, cyc + SYNC + 1, 3, ST_WAIT_LOCK);
        step(6);
        sbus.pll_locked = 1'b1;
        step(6);
        sbus.pll_locked = 1'b0;
        step(1);
        sbus.pll_locked = 1'b1;
        push_small(1'b1, cyc + S_LAT, 3, ST_RUN);

        step(LAT);
        check("main_run_state", bus.state, ST_RUN);
        check("main_run_ready", bus.ready, 1'b1);

        // Lock loss in RUN, then relock.
        bus.pll_locked = 1'b0;
        push_main(1'b0, cyc + SYNC + 1, 1, ST_WAIT_LOCK);
        step(10);
        check("after_loss_state", bus.state, ST_WAIT_LOCK);
        bus.pll_locked = 1'b1;
        push_main(1'b1, cyc + LAT, 1, ST_RUN);
        step(LAT + 5);

        // Glitch during FILTER: only the second rise qualifies.
        bus.pll_locked = 1'b0;
        push_main(1'b0, cyc + SYNC + 1, 2, ST_WAIT_LOCK);
        step(10);
        bus.pll_locked = 1'b1;
        step(500);
        bus.pll_locked = 1'b0;
        step(1);
        bus.pll_locked = 1'b1;
        push_main(1'b1, cyc + LAT, 2, ST_RUN);
        step(LAT + 5);
        loss = 2;

`ifdef RSTGEN_SOFTRST_EN
        // Single-cycle soft request: HOLD_CYCLES of reset, counter untouched.
        bus.soft_req = 1'b1;
        push_main(1'b0, cyc + 1, loss, ST_HOLD);
        push_main(1'b1, cyc + 1 + HC, loss, ST_RUN);
        step(1);
        bus.soft_req = 1'b0;
        step(HC + 5);

        // Soft request coinciding with lock loss: lock loss wins.
        bus.pll_locked = 1'b0;
        step(2);
        bus.soft_req = 1'b1;
        loss = loss + 1;
        push_main(1'b0, cyc + 1, loss, ST_WAIT_LOCK);
        step(1);
        bus.soft_req = 1'b0;
        step(5);
        bus.pll_locked = 1'b1;
        push_main(1'b1, cyc + LAT, loss, ST_RUN);
        step(LAT + 5);
`endif

        // resetn asserted mid-HOLD with cnt==7.
        loss = loss + 1;
        bus.pll_locked = 1'b0;
        push_main(1'b0, cyc + SYNC + 1, loss, ST_WAIT_LOCK);
        step(10);
        bus.pll_locked = 1'b1;
        c = cyc;
        step(SYNC + 1 + LF + 7);
        check("pre_reset_hold_state", bus.state, ST_HOLD);
        check("pre_reset_cycle", cyc, c + SYNC + 1 + LF + 7);
        resetn = 1'b0;
        step(1);
        check("mid_reset_state", bus.state, ST_WAIT_LOCK);
        check("mid_reset_sys_resetn", bus.sys_resetn, 1'b0);
        check("mid_reset_ready", bus.ready, 1'b0);
        check("mid_reset_loss", bus.lock_loss_cnt, 0);
        resetn = 1'b1;
        push_main(1'b1, cyc + LAT, 0, ST_RUN);
        step(LAT + 5);

        check("main_queue_empty", exp_q.size(), 0);
        check("small_queue_empty", sexp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
